instruction_fetch: RTL and testbench

Pipeline stage directly upstream of `instruction_decode`. It owns the program counter and issues one outstanding word fetch at a time to instruction memory over a request/response handshake. It registers the returned word together with its PC and PC+4 toward decode. Redirects from the execute stage (taken branches and jumps) take priority, and any in-flight response belonging to the old path is discarded.

---
 rtl/instruction_fetch_pkg.sv | 15 +
 rtl/instruction_fetch.sv | 116 +++++++++++
 tb/tb_instruction_fetch.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared constants and state encoding for the fetch stage
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_VALID = 3'd2,
        ST_DROP  = 3'd3
    } if_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding instruction fetch stage with redirect
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] pc_next_out
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic        valid_q, valid_d;

    logic        accept;
    logic [31:0] pc_inc;
    logic [31:0] target;

    // Request is masked during reset so memory never sees a request from a held-reset stage.
    assign imem_req  = (state_q == ST_REQ) && rst_n;
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;
    assign pc_inc    = pc_q + PC_INCR;
    assign target    = redirect_pc & ~32'h3;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        pc_next_d = pc_next_q;
        valid_d   = valid_q;

        if (redirect_valid) begin
            pc_d = target;
            case (state_q)
                ST_REQ:   state_d = accept ? ST_DROP : ST_REQ;
                ST_WAIT:  state_d = imem_rvalid ? ST_REQ : ST_DROP;
                ST_VALID: begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = ST_REQ;
                end
                ST_DROP:  state_d = imem_rvalid ? ST_REQ : ST_DROP;
                default:  state_d = ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (accept) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        instr_d   = imem_rdata;
                        pc_out_d  = pc_q;
                        pc_next_d = pc_inc;
                        valid_d   = 1'b1;
                        pc_d      = pc_inc;
                        state_d   = ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (id_ready) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                        state_d = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid) state_d = ST_REQ;
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            pc_out_q  <= RESET_PC;
            pc_next_q <= RESET_PC + PC_INCR;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
        end
    end

    assign if_valid    = valid_q;
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign pc_next_out = pc_next_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized scoreboard bench for instruction_fetch
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] pc_next_out;

    instruction_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .instruction    (instruction),
        .pc_out         (pc_out),
        .pc_next_out    (pc_next_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int consumed = 0;

    // Architectural program stream: sequential PCs from the last reset or redirect target.
    logic [31:0] exp_q[$];
    logic [31:0] fetch_exp;

    bit          pending = 1'b0;
    int          cnt = 0;
    int          lat = 1;
    logic [31:0] paddr = '0;
    bit          ideal = 1'b0;
    bit          allow_redirect = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refill(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic issue_redirect(input logic [31:0] raw);
        logic [31:0] t;
        t = {raw[31:2], 2'b00};
        redirect_valid = 1'b1;
        redirect_pc    = raw;
        refill(t);
        fetch_exp = t;
    endtask

    // Memory side and fetch-address checks, evaluated on the falling edge.
    task automatic observe();
        if (!rst_n) return;
        if (imem_req) check("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
        if (imem_rvalid) pending = 1'b0;
        if (imem_req && imem_ready) begin
            check("one_outstanding", {31'b0, pending}, 32'h0);
            if (!redirect_valid) begin
                check("fetch_addr", imem_addr, fetch_exp);
                fetch_exp = fetch_exp + 32'd4;
            end
            pending = 1'b1;
            paddr   = imem_addr;
            lat     = ideal ? 1 : int'($urandom_range(1, 4));
            cnt     = lat;
        end
    endtask

    task automatic drive();
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        imem_rvalid    = 1'b0;
        imem_rdata     = $urandom;
        if (pending) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = paddr ^ KEY;
            end
        end
        if (ideal) begin
            imem_ready = 1'b1;
            id_ready   = 1'b1;
        end else begin
            imem_ready = ($urandom_range(0, 9) < 7);
            id_ready   = ($urandom_range(0, 9) < 6);
        end
        if (allow_redirect && $urandom_range(0, 99) < 5)
            issue_redirect(($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom);
    endtask

    task automatic cycle();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic reset_checks();
        check("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("rst_instr", instruction, NOP);
        check("rst_pc_out", pc_out, RST_PC);
        check("rst_pc_next", pc_next_out, RST_PC + 32'd4);
        check("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check("rst_imem_addr", imem_addr, RST_PC);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        pending        = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        refill(RST_PC);
        fetch_exp = RST_PC;
        repeat (2) begin
            @(negedge clk);
            reset_checks();
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("post_rst_addr", imem_addr, RST_PC);
        observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    // Monitor: pops the expected stream on every completed transfer to decode.
    bit          hold_prev = 1'b0;
    logic [31:0] prev_instr, prev_pc, prev_next;
    logic        prev_valid;
    int          last_c = -1;

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n) begin
            if (if_valid) check("no_req_while_valid", {31'b0, imem_req}, 32'h0);
            else          check("nop_when_idle", instruction, NOP);
            if (hold_prev) begin
                check("stall_valid", {31'b0, if_valid}, {31'b0, prev_valid});
                check("stall_instr", instruction, prev_instr);
                check("stall_pc", pc_out, prev_pc);
                check("stall_pc_next", pc_next_out, prev_next);
            end
            if (if_valid && id_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_empty: got pc %h expected none", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    check("pc_out", pc_out, e);
                    check("instruction", instruction, e ^ KEY);
                    check("pc_next_out", pc_next_out, e + 32'd4);
                end
                if (ideal && last_c >= 0) check("throughput_gap", 32'(cyc - last_c), 32'd3);
                last_c = cyc;
                consumed++;
            end
            hold_prev  = if_valid && !id_ready && !redirect_valid;
            prev_valid = if_valid;
            prev_instr = instruction;
            prev_pc    = pc_out;
            prev_next  = pc_next_out;
        end else begin
            hold_prev = 1'b0;
            last_c    = -1;
        end
    end

    initial begin
        int guard;
        rst_n          = 1'b0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        refill(RST_PC);
        fetch_exp = RST_PC;

        repeat (3) begin
            @(negedge clk);
            reset_checks();
        end
        @(posedge clk);
        #1;
        ideal      = 1'b1;
        imem_ready = 1'b1;
        id_ready   = 1'b1;
        rst_n      = 1'b1;

        repeat (40) cycle();

        // Redirect to an unaligned target while a response is outstanding.
        ideal = 1'b0;
        guard = 0;
        do begin
            cycle();
            guard++;
        end while (!(pending && !imem_rvalid) && guard < 100);
        check("wait_found", {31'b0, pending}, 32'h1);
        issue_redirect(32'h0000_0103);
        repeat (30) cycle();

        allow_redirect = 1'b1;
        repeat (1500) cycle();
        allow_redirect = 1'b0;

        // Address wrap at the top of memory.
        repeat (10) cycle();
        issue_redirect(32'hFFFF_FFFC);
        repeat (40) cycle();

        // Asynchronous reset while a fetch is in flight.
        guard = 0;
        do begin
            cycle();
            guard++;
        end while (!(pending && !imem_rvalid && !redirect_valid) && guard < 100);
        check("wait_found_rst", {31'b0, pending}, 32'h1);
        do_reset();

        allow_redirect = 1'b1;
        repeat (300) cycle();
        allow_redirect = 1'b0;
        repeat (20) cycle();

        tests++;
        if (consumed < 100) begin
            fails++;
            $display("FAIL deliveries: got %0d expected at least 100", consumed);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
